hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/flow controller for the 5-stage core; generates the stall and flush
//  controls consumed by the IF/ID and ID/EX pipeline registers. Detects load-use hazards,
//  holds the front end during multicycle MUL/DIV ops, and extends branch/jump redirect
//  flushes to cover synchronous-BRAM fetch latency. Sits beside the decode stage.
// PARAMETERS
//  FETCH_LAT   1   extra cycles flush_if_id is held after a redirect (0 = redirect cycle only)
//  MD_MAX_CYC  34  watchdog limit on cycles spent in MD_WAIT before md_timeout is raised
// PORTS
//  clk          in   1  core clock
//  rst          in   1  asynchronous reset, active-high
//  id_rs1       in   5  rs1 index of instruction in ID
//  id_rs2       in   5  rs2 index of instruction in ID
//  id_uses_rs1  in   1  instruction in ID reads rs1
//  id_uses_rs2  in   1  instruction in ID reads rs2
//  ex_rd        in   5  destination index of instruction in EX
//  ex_mem_read  in   1  instruction in EX is a load
//  ex_redirect  in   1  branch taken / jump resolved in EX this cycle
//  ex_md_start  in   1  MUL/DIV instruction in EX starts the multicycle unit
//  md_done      in   1  multicycle unit result valid (1-cycle pulse)
//  stall_if     out  1  hold PC / fetch
//  stall_id     out  1  hold IF/ID register
//  stall_ex     out  1  hold ID/EX register (EX op not yet complete)
//  flush_if_id  out  1  zero IF/ID register next edge
//  flush_id_ex  out  1  zero ID/EX register next edge (bubble insert)
//  md_timeout   out  1  sticky error: MD_WAIT exceeded MD_MAX_CYC
// BEHAVIOUR
//  - Reset: state=RUN, counters=0, md_timeout=0; all outputs 0 while rst=1. Reset mid-op
//    drops to RUN immediately; no pending stall/flush survives reset.
//  - Load-use hit = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) |
//    (id_uses_rs2 & id_rs2==ex_rd)). x0 never creates a hazard.
//  - Outputs are combinational from state + inputs (same-cycle response); state is registered.
//  - FSM states: RUN, MD_WAIT, REDIRECT. Priority in RUN: redirect > md_start > load-use.
//  - RUN:
//      ex_redirect: flush_if_id=1, flush_id_ex=1; if FETCH_LAT>0 -> REDIRECT, cnt=FETCH_LAT.
//      ex_md_start & !md_done: stall_if=stall_id=stall_ex=1 -> MD_WAIT, cnt=1.
//      ex_md_start & md_done (same-cycle result): no stall, stay RUN.
//      load-use hit: stall_if=stall_id=1, flush_id_ex=1 for exactly one cycle; stay RUN.
//  - MD_WAIT: stall_if=stall_id=stall_ex=1 every cycle md_done=0; cnt increments.
//    In the md_done cycle, all stalls deassert (release same cycle) -> RUN.
//    ex_redirect and load-use ignored (EX holds the MD op). If cnt reaches MD_MAX_CYC:
//    md_timeout<=1 (sticky until rst), stalls released, -> RUN.
//  - REDIRECT: flush_if_id=1 for cnt cycles (cnt decrements; -> RUN when cnt hits 1 this cycle);
//    load-use suppressed (ID holds a bubble). A new ex_redirect reloads cnt=FETCH_LAT and
//    asserts flush_id_ex.
//  - stall_ex=1 implies stall_if=stall_id=1. flush_* and stall_ex are never both 1.
//  - Counter width $clog2(MD_MAX_CYC+1); no wrap: it saturates at MD_MAX_CYC.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_load_stalls, perf_md_stalls, perf_flushes
//    (32 bit each, saturating at 32'hFFFF_FFFF, cleared by rst): +1 per load-use bubble
//    cycle, per MD_WAIT stall cycle, per cycle with flush_if_id=1 respectively.
//  Undefined: those ports and counters do not exist; other behaviour identical.
// TESTING
//  1 Reset: rst=1 for 3 cycles mid-MD_WAIT -> all outputs 0, RUN on release, md_timeout=0.
//  2 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> stall_if/id=1,
//    flush_id_ex=1 for exactly 1 cycle; same with ex_rd=0 -> no stall.
//  3 MUL/DIV: ex_md_start pulse, md_done 10 cycles later -> stall_ex=1 for 10 cycles,
//    released in the md_done cycle; ex_redirect pulsed mid-wait -> no flush.
//  4 Redirect, FETCH_LAT=2: ex_redirect 1 cycle -> flush_id_ex=1 for 1 cycle,
//    flush_if_id=1 for 3 cycles; simultaneous load-use in same cycle -> no stall.
//  5 Watchdog, MD_MAX_CYC=34: md_start, md_done never -> stalls drop after 34 cycles,
//    md_timeout=1 and stays 1 until rst.
//  6 HAZARD_PERF_EN: scenario 2 then 3 -> perf_load_stalls=1, perf_md_stalls=10.

Source files
------------

// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_if
//  Brief    : Decode/execute side signals exchanged with the hazard controller.
//             master = pipeline side (drives hazard sources, consumes controls)
//             slave  = hazard_ctrl (consumes hazard sources, drives controls)
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       ex_md_start;
    logic       md_done;
    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       md_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_md_start, md_done,
        input  stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, md_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_md_start, md_done,
        output stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, md_timeout
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Stall/flush generator for the 5-stage core. Handles load-use
//             bubbles, multicycle MUL/DIV holds (with watchdog) and redirect
//             flushes stretched over the fetch BRAM latency.
//             Optional macro HAZARD_PERF_EN adds three saturating 32-bit
//             performance counters (load bubbles, MD stall cycles, IF flushes).
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int FETCH_LAT  = 1,
    parameter int MD_MAX_CYC = 34
) (
    input  wire logic  clk,
    input  wire logic  rst,
    hazard_if.slave    hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_load_stalls,
    output logic [31:0] perf_md_stalls,
    output logic [31:0] perf_flushes
`endif
);

    // One counter serves both the MD watchdog and the redirect countdown,
    // so it must hold the larger of the two limits.
    localparam int c_CNT_MAX_RAW = (MD_MAX_CYC > FETCH_LAT) ? MD_MAX_CYC : FETCH_LAT;
    localparam int c_CNT_MAX     = (c_CNT_MAX_RAW < 1) ? 1 : c_CNT_MAX_RAW;
    localparam int c_CNT_W       = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_FETCH_LAT = c_CNT_W'(FETCH_LAT);
    localparam logic [c_CNT_W-1:0] c_MD_MAX    = c_CNT_W'(MD_MAX_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MD_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_REDIRECT = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_md_timeout;
    logic               w_timeout_set;

    logic w_load_use;
    logic w_stall_if;
    logic w_stall_id;
    logic w_stall_ex;
    logic w_flush_if_id;
    logic w_flush_id_ex;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                        ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // State, shared counter and sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_RUN;
            r_cnt        <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_timeout_set) begin
                r_md_timeout <= 1'b1;
            end
        end
    end

    // Next state: redirect beats MD start beats load-use while running.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_set = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (hz.ex_redirect) begin
                    if (FETCH_LAT > 0) begin
                        w_state_nxt = c_ST_REDIRECT;
                        w_cnt_nxt   = c_FETCH_LAT;
                    end
                end else if (hz.ex_md_start && !hz.md_done) begin
                    w_state_nxt = c_ST_MD_WAIT;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            c_ST_MD_WAIT: begin
                if (hz.md_done) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_MD_MAX) begin
                    w_state_nxt   = c_ST_RUN;
                    w_cnt_nxt     = '0;
                    w_timeout_set = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_REDIRECT: begin
                if (hz.ex_redirect) begin
                    w_cnt_nxt = c_FETCH_LAT;
                end else if (r_cnt <= c_CNT_ONE) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Same-cycle controls from state and inputs; forced quiet while in reset.
    always_comb begin
        w_stall_if    = 1'b0;
        w_stall_id    = 1'b0;
        w_stall_ex    = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_RUN: begin
                    if (hz.ex_redirect) begin
                        w_flush_if_id = 1'b1;
                        w_flush_id_ex = 1'b1;
                    end else if (hz.ex_md_start) begin
                        // A same-cycle result needs no hold at all.
                        if (!hz.md_done) begin
                            w_stall_if = 1'b1;
                            w_stall_id = 1'b1;
                            w_stall_ex = 1'b1;
                        end
                    end else if (w_load_use) begin
                        w_stall_if    = 1'b1;
                        w_stall_id    = 1'b1;
                        w_flush_id_ex = 1'b1;
                    end
                end
                c_ST_MD_WAIT: begin
                    // EX holds the MD op, so redirect/load-use cannot occur here.
                    if (!hz.md_done && (r_cnt < c_MD_MAX)) begin
                        w_stall_if = 1'b1;
                        w_stall_id = 1'b1;
                        w_stall_ex = 1'b1;
                    end
                end
                c_ST_REDIRECT: begin
                    // ID holds a bubble, so load-use is not evaluated.
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = hz.ex_redirect;
                end
                default: begin
                    w_stall_if = 1'b0;
                end
            endcase
        end
    end

    assign hz.stall_if    = w_stall_if;
    assign hz.stall_id    = w_stall_id;
    assign hz.stall_ex    = w_stall_ex;
    assign hz.flush_if_id = w_flush_if_id;
    assign hz.flush_id_ex = w_flush_id_ex;
    assign hz.md_timeout  = r_md_timeout;

`ifdef HAZARD_PERF_EN
    // Only the load-use case raises stall_id together with flush_id_ex.
    logic w_perf_load;
    assign w_perf_load = w_stall_id && w_flush_id_ex;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_stalls <= '0;
            perf_md_stalls   <= '0;
            perf_flushes     <= '0;
        end else begin
            if (w_perf_load && (perf_load_stalls != 32'hFFFF_FFFF)) begin
                perf_load_stalls <= perf_load_stalls + 32'd1;
            end
            if (w_stall_ex && (perf_md_stalls != 32'hFFFF_FFFF)) begin
                perf_md_stalls <= perf_md_stalls + 32'd1;
            end
            if (w_flush_if_id && (perf_flushes != 32'hFFFF_FFFF)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Scoreboard bench for hazard_ctrl: directed scenarios followed by
//             randomized traffic, checked against a cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int FL  = 2;
    localparam int MDM = 34;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       redir;
        logic       mds;
        logic       mdd;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_if hif ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_load_stalls;
    logic [31:0] perf_md_stalls;
    logic [31:0] perf_flushes;
`endif

    hazard_ctrl #(.FETCH_LAT(FL), .MD_MAX_CYC(MDM)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
`ifdef HAZARD_PERF_EN
        ,
        .perf_load_stalls (perf_load_stalls),
        .perf_md_stalls   (perf_md_stalls),
        .perf_flushes     (perf_flushes)
`endif
    );

    // Expected {stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, md_timeout}
    logic [5:0] exp_q[$];
    int         cyc_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state in the specification's own terms.
    bit     m_md_busy     = 0;
    int     m_md_cycles   = 0;   // cycles the MD op has been waited on
    int     m_flush_left  = 0;   // extra IF flush cycles still owed
    bit     m_timeout     = 0;
    longint m_perf_load   = 0;
    longint m_perf_md     = 0;
    longint m_perf_flush  = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Apply one cycle of stimulus and push the predicted response.
    task automatic step(input stim_t s);
        logic [5:0] e;
        bit hit;
        @(posedge clk);
        #1;
        rst                 = s.rst;
        hif.id_rs1          = s.rs1;
        hif.id_rs2          = s.rs2;
        hif.ex_rd           = s.rd;
        hif.id_uses_rs1     = s.u1;
        hif.id_uses_rs2     = s.u2;
        hif.ex_mem_read     = s.mr;
        hif.ex_redirect     = s.redir;
        hif.ex_md_start     = s.mds;
        hif.md_done         = s.mdd;
        cyc++;
        hit = s.mr && (s.rd != 0) &&
              ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
        e = '0;
        if (s.rst) begin
            m_md_busy    = 0;
            m_md_cycles  = 0;
            m_flush_left = 0;
            m_timeout    = 0;
            m_perf_load  = 0;
            m_perf_md    = 0;
            m_perf_flush = 0;
        end else begin
            e[0] = m_timeout;
            if (m_md_busy) begin
                if (s.mdd) begin
                    m_md_busy = 0;
                end else if (m_md_cycles >= MDM) begin
                    m_md_busy = 0;
                    m_timeout = 1;
                end else begin
                    e[5:3] = 3'b111;
                    m_md_cycles++;
                end
            end else if (m_flush_left > 0) begin
                e[2] = 1'b1;
                if (s.redir) begin
                    e[1] = 1'b1;
                    m_flush_left = FL;
                end else begin
                    m_flush_left--;
                end
            end else if (s.redir) begin
                e[2] = 1'b1;
                e[1] = 1'b1;
                m_flush_left = FL;
            end else if (s.mds) begin
                if (!s.mdd) begin
                    e[5:3] = 3'b111;
                    m_md_busy   = 1;
                    m_md_cycles = 1;
                end
            end else if (hit) begin
                e[5] = 1'b1;
                e[4] = 1'b1;
                e[1] = 1'b1;
                m_perf_load++;
            end
            if (e[3]) m_perf_md++;
            if (e[2]) m_perf_flush++;
        end
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
    endtask

    // Monitor: compares presented outputs against the oldest prediction.
    initial begin
        logic [5:0] e;
        logic [5:0] a;
        int c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                a = {hif.stall_if, hif.stall_id, hif.stall_ex,
                     hif.flush_if_id, hif.flush_id_ex, hif.md_timeout};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL ctrl_outputs cycle=%0d actual=%b expected=%b (stall_if,stall_id,stall_ex,flush_if_id,flush_id_ex,md_timeout)",
                             c, a, e);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        hif.id_rs1 = '0; hif.id_rs2 = '0; hif.ex_rd = '0;
        hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
        hif.ex_mem_read = 1'b0; hif.ex_redirect = 1'b0;
        hif.ex_md_start = 1'b0; hif.md_done = 1'b0;

        // Reset state.
        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        step(idle()); step(idle());

        // Load-use via rs2, then the x0 variant.
        s = idle(); s.mr = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1;
        step(s); step(idle());
        s.rd = 5'd0; s.rs2 = 5'd0;
        step(s); step(idle());
        // Load-use via rs1; matching register but not used -> no hazard.
        s = idle(); s.mr = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1;
        step(s);
        s.u1 = 0;
        step(s); step(idle());

        // MUL/DIV with done 10 cycles later, redirect mid-wait ignored.
        s = idle(); s.mds = 1; step(s);
        for (int i = 1; i < 10; i++) begin
            s = idle(); s.redir = (i == 5); step(s);
        end
        s = idle(); s.mdd = 1; step(s);
        step(idle());

        // MD start with same-cycle result.
        s = idle(); s.mds = 1; s.mdd = 1; step(s); step(idle());

        // Redirect with simultaneous load-use, load-use during the flush window.
        s = idle(); s.redir = 1; s.mr = 1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1;
        step(s);
        s.redir = 0; step(s);
        step(idle()); step(idle()); step(idle());
        // Back-to-back redirect reloads the window.
        s = idle(); s.redir = 1; step(s); step(idle()); step(s);
        for (int i = 0; i < 4; i++) step(idle());

        // Watchdog: done never arrives.
        s = idle(); s.mds = 1; step(s);
        for (int i = 0; i < 40; i++) step(idle());
        s = idle(); s.mds = 1; s.mdd = 1; step(s);
        step(idle());

        // Reset during an MD wait with hazard inputs active.
        s = idle(); s.mds = 1; step(s);
        for (int i = 0; i < 5; i++) step(idle());
        s = idle(); s.rst = 1; s.redir = 1; s.mr = 1; s.rd = 5'd9; s.rs2 = 5'd9; s.u2 = 1;
        step(s); step(s); step(s);
        for (int i = 0; i < 3; i++) step(idle());

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(199) == 0);
            s.rs1   = 5'($urandom_range(3));
            s.rs2   = 5'($urandom_range(3));
            s.rd    = 5'($urandom_range(3));
            s.u1    = 1'($urandom_range(1));
            s.u2    = 1'($urandom_range(1));
            s.mr    = ($urandom_range(9) < 4);
            s.redir = ($urandom_range(9) == 0);
            s.mds   = ($urandom_range(9) == 0);
            s.mdd   = ($urandom_range(99) < 8);
            step(s);
        end
        step(idle());

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", exp_q.size());
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_load_stalls !== 32'(m_perf_load)) begin
            failures++;
            $display("FAIL perf_load_stalls actual=%0d expected=%0d", perf_load_stalls, m_perf_load);
        end
        checks++;
        if (perf_md_stalls !== 32'(m_perf_md)) begin
            failures++;
            $display("FAIL perf_md_stalls actual=%0d expected=%0d", perf_md_stalls, m_perf_md);
        end
        checks++;
        if (perf_flushes !== 32'(m_perf_flush)) begin
            failures++;
            $display("FAIL perf_flushes actual=%0d expected=%0d", perf_flushes, m_perf_flush);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
